// File: rtl/regfile_sb.sv
// regfile_sb: register file with NUM_READ registered read ports, one write
// port with write-first bypass, an optional hardwired-zero register 0 and a
// per-register busy scoreboard. Decode reserves a destination and writeback
// releases it. Each read returns the data together with the busy flag that
// holds after the same edge, so the hazard unit needs no tracking of its own.
module regfile_sb #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_READ      = 2,
  parameter int ZERO_REG      = 1
) (
  input  logic                              CLK,
  input  logic                              RSTN,
  input  logic                              WE3,
  input  logic [ADDRESS_WIDTH-1:0]          A3,
  input  logic [DATA_WIDTH-1:0]             WD3,
  input  logic [NUM_READ-1:0]               RE,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] RA,
  output logic [NUM_READ*DATA_WIDTH-1:0]    RD,
  output logic [NUM_READ-1:0]               RBUSY,
  input  logic                              RSV_VALID,
  input  logic [ADDRESS_WIDTH-1:0]          RSV_ADDR,
  output logic                              RSV_READY,
  output logic [2**ADDRESS_WIDTH-1:0]       BUSY_VEC
);

  localparam int DEPTH    = 2**ADDRESS_WIDTH;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]      busy_reg;
  logic [DEPTH-1:0]      busy_next;
  logic [DEPTH-1:0]      release_mask;
  logic [DEPTH-1:0]      reserve_mask;
  logic                  a3_is_zero;
  logic                  rsv_is_zero;

  // Register 0 is only special when the hardwired-zero option is built in.
  assign a3_is_zero  = HAS_ZERO && (A3 == '0);
  assign rsv_is_zero = HAS_ZERO && (RSV_ADDR == '0);

  // A register being released this cycle may be handed to a new owner at once.
  assign RSV_READY = !busy_reg[RSV_ADDR] || (WE3 && (A3 == RSV_ADDR));

  assign BUSY_VEC = busy_reg;

  // Writeback releases its destination register.
  always_comb begin
    release_mask = '0;
    if (WE3) begin
      release_mask[A3] = 1'b1;
    end
  end

  // Accepted reservations mark the register busy; register 0 never becomes busy.
  always_comb begin
    reserve_mask = '0;
    if (RSV_VALID && RSV_READY && !rsv_is_zero) begin
      reserve_mask[RSV_ADDR] = 1'b1;
    end
  end

  // Set wins over clear, so a same-cycle release+reserve leaves the new owner.
  assign busy_next = (busy_reg & ~release_mask) | reserve_mask;

  // Scoreboard state.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  // Register storage; writes to a hardwired register 0 are dropped.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (WE3 && !a3_is_zero) begin
      mem_reg[A3] <= WD3;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [ADDRESS_WIDTH-1:0] ra_w;
      logic [DATA_WIDTH-1:0]    rd_reg;
      logic                     rbusy_reg;

      assign ra_w = RA[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];

      // Enabled reads capture zero / bypassed write data / stored data, plus
      // the post-edge busy flag; disabled ports hold their last result.
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          rd_reg    <= '0;
          rbusy_reg <= 1'b0;
        end else if (RE[gi]) begin
          if (HAS_ZERO && (ra_w == '0)) begin
            rd_reg <= '0;
          end else if (WE3 && (A3 == ra_w)) begin
            rd_reg <= WD3;
          end else begin
            rd_reg <= mem_reg[ra_w];
          end
          rbusy_reg <= busy_next[ra_w];
        end
      end

      assign RD[gi*DATA_WIDTH +: DATA_WIDTH] = rd_reg;
      assign RBUSY[gi]                       = rbusy_reg;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb (4 read ports, hardwired x0). Each scenario task
// drives one cycle at a time, pushes the read results it expects into a
// queue, and pops/compares them once the clock edge has produced the outputs.
module tb_regfile_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 4;

  logic              clk;
  logic              rstn;
  logic              we3;
  logic [AW-1:0]     a3;
  logic [DW-1:0]     wd3;
  logic [NR-1:0]     re;
  logic [NR*AW-1:0]  ra;
  logic [NR*DW-1:0]  rd;
  logic [NR-1:0]     rbusy;
  logic              rsv_valid;
  logic [AW-1:0]     rsv_addr;
  logic              rsv_ready;
  logic [2**AW-1:0]  busy_vec;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  regfile_sb #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_READ(NR),
    .ZERO_REG(1)
  ) dut (
    .CLK(clk),
    .RSTN(rstn),
    .WE3(we3),
    .A3(a3),
    .WD3(wd3),
    .RE(re),
    .RA(ra),
    .RD(rd),
    .RBUSY(rbusy),
    .RSV_VALID(rsv_valid),
    .RSV_ADDR(rsv_addr),
    .RSV_READY(rsv_ready),
    .BUSY_VEC(busy_vec)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [NR*AW-1:0] pack_ra(input logic [AW-1:0] p0, input logic [AW-1:0] p1,
                                               input logic [AW-1:0] p2, input logic [AW-1:0] p3);
    return {p3, p2, p1, p0};
  endfunction

  task automatic push_exp(input string name, input int port, input logic [31:0] data, input logic busy);
    exp_t x;
    x.name = name;
    x.port = port;
    x.data = data;
    x.busy = busy;
    exp_q.push_back(x);
  endtask

  task automatic idle();
    we3       = 1'b0;
    a3        = '0;
    wd3       = '0;
    re        = '0;
    ra        = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
  endtask

  // Advance one edge, sample 1 time unit later, then return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    // Put some state in place so the reset has something to clear.
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'h0000_AAAA;
    tick();
    re = 4'b0001; ra = pack_ra(5'd5, 5'd0, 5'd0, 5'd0);
    rsv_valid = 1'b1; rsv_addr = 5'd5;
    push_exp("pre_reset_read", 0, 32'h0000_AAAA, 1'b1);
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd[e.port*DW +: DW] !== e.data || rbusy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s port%0d: RD=%h RBUSY=%b, expected RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port], e.data, e.busy);
      end else $display("ok   %s port%0d RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port]);
    end
    checks++;
    if (busy_vec !== 32'h0000_0020) begin
      errors++;
      $display("FAIL pre_reset_busy: BUSY_VEC=%h expected %h", busy_vec, 32'h0000_0020);
    end
    // Asynchronous reset mid-cycle: outputs clear without a clock edge.
    rsv_addr = 5'd5;
    rstn = 1'b0;
    #2;
    checks++;
    if (busy_vec !== '0 || rsv_ready !== 1'b1 || rd !== '0 || rbusy !== '0) begin
      errors++;
      $display("FAIL async_reset: BUSY_VEC=%h RSV_READY=%b RD=%h RBUSY=%b, expected all zero and RSV_READY=1", busy_vec, rsv_ready, rd, rbusy);
    end else $display("ok   async_reset outputs cleared");
    @(negedge clk);
    rstn = 1'b1;
    re = 4'b1111; ra = pack_ra(5'd0, 5'd5, 5'd31, 5'd5);
    push_exp("reset_read_x0", 0, 32'h0, 1'b0);
    push_exp("reset_read_x5", 1, 32'h0, 1'b0);
    push_exp("reset_read_x31", 2, 32'h0, 1'b0);
    push_exp("reset_read_x5b", 3, 32'h0, 1'b0);
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd[e.port*DW +: DW] !== e.data || rbusy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s port%0d: RD=%h RBUSY=%b, expected RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port], e.data, e.busy);
      end else $display("ok   %s port%0d RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port]);
    end
    checks++;
    if (busy_vec !== '0) begin
      errors++;
      $display("FAIL reset_busy_vec: BUSY_VEC=%h expected 0", busy_vec);
    end
  endtask

  task automatic test_bypass();
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'hDEAD_BEEF;
    re = 4'b0001; ra = pack_ra(5'd7, 5'd0, 5'd0, 5'd0);
    push_exp("bypass_x7", 0, 32'hDEAD_BEEF, 1'b0);
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd[e.port*DW +: DW] !== e.data || rbusy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s port%0d: RD=%h RBUSY=%b, expected RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port], e.data, e.busy);
      end else $display("ok   %s port%0d RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port]);
    end
    re = 4'b0010; ra = pack_ra(5'd0, 5'd7, 5'd0, 5'd0);
    push_exp("stored_x7", 1, 32'hDEAD_BEEF, 1'b0);
    push_exp("hold_port0", 0, 32'hDEAD_BEEF, 1'b0);
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd[e.port*DW +: DW] !== e.data || rbusy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s port%0d: RD=%h RBUSY=%b, expected RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port], e.data, e.busy);
      end else $display("ok   %s port%0d RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port]);
    end
  endtask

  task automatic test_zero_reg();
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'h1234_5678;
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    re = 4'b0001; ra = pack_ra(5'd0, 5'd0, 5'd0, 5'd0);
    push_exp("x0_write_bypass", 0, 32'h0, 1'b0);
    #1;
    checks++;
    if (rsv_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_rsv_ready_w: RSV_READY=%b expected 1", rsv_ready);
    end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd[e.port*DW +: DW] !== e.data || rbusy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s port%0d: RD=%h RBUSY=%b, expected RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port], e.data, e.busy);
      end else $display("ok   %s port%0d RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port]);
    end
    checks++;
    if (busy_vec !== '0) begin
      errors++;
      $display("FAIL x0_busy_after_rsv: BUSY_VEC=%h expected 0", busy_vec);
    end
    // Reserve x0 on its own (no write) and read x0 from storage.
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    re = 4'b0100; ra = pack_ra(5'd0, 5'd0, 5'd0, 5'd0);
    push_exp("x0_stored_read", 2, 32'h0, 1'b0);
    #1;
    checks++;
    if (rsv_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_rsv_ready: RSV_READY=%b expected 1", rsv_ready);
    end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd[e.port*DW +: DW] !== e.data || rbusy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s port%0d: RD=%h RBUSY=%b, expected RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port], e.data, e.busy);
      end else $display("ok   %s port%0d RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port]);
    end
    checks++;
    if (busy_vec !== '0) begin
      errors++;
      $display("FAIL x0_busy_vec: BUSY_VEC=%h expected 0", busy_vec);
    end
  endtask

  task automatic test_scoreboard();
    // Reserve x10 while reading it: the read already sees it busy.
    rsv_valid = 1'b1; rsv_addr = 5'd10;
    re = 4'b0001; ra = pack_ra(5'd10, 5'd0, 5'd0, 5'd0);
    push_exp("rsv_read_x10", 0, 32'h0, 1'b1);
    #1;
    checks++;
    if (rsv_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsv_x10_ready: RSV_READY=%b expected 1", rsv_ready);
    end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd[e.port*DW +: DW] !== e.data || rbusy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s port%0d: RD=%h RBUSY=%b, expected RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port], e.data, e.busy);
      end else $display("ok   %s port%0d RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port]);
    end
    checks++;
    if (busy_vec !== 32'h0000_0400) begin
      errors++;
      $display("FAIL rsv_x10_busy: BUSY_VEC=%h expected %h", busy_vec, 32'h0000_0400);
    end
    // Second reservation of x10 must be refused.
    rsv_valid = 1'b1; rsv_addr = 5'd10;
    re = 4'b0010; ra = pack_ra(5'd0, 5'd10, 5'd0, 5'd0);
    push_exp("busy_read_x10", 1, 32'h0, 1'b1);
    #1;
    checks++;
    if (rsv_ready !== 1'b0) begin
      errors++;
      $display("FAIL rsv_x10_again: RSV_READY=%b expected 0", rsv_ready);
    end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd[e.port*DW +: DW] !== e.data || rbusy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s port%0d: RD=%h RBUSY=%b, expected RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port], e.data, e.busy);
      end else $display("ok   %s port%0d RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port]);
    end
    // Writeback releases x10; a same-edge read sees the new data and not busy.
    we3 = 1'b1; a3 = 5'd10; wd3 = 32'h0000_0055;
    re = 4'b0001; ra = pack_ra(5'd10, 5'd0, 5'd0, 5'd0);
    push_exp("release_read_x10", 0, 32'h0000_0055, 1'b0);
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd[e.port*DW +: DW] !== e.data || rbusy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s port%0d: RD=%h RBUSY=%b, expected RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port], e.data, e.busy);
      end else $display("ok   %s port%0d RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port]);
    end
    checks++;
    if (busy_vec !== '0) begin
      errors++;
      $display("FAIL release_x10_busy: BUSY_VEC=%h expected 0", busy_vec);
    end
    re = 4'b0010; ra = pack_ra(5'd0, 5'd10, 5'd0, 5'd0);
    push_exp("stored_read_x10", 1, 32'h0000_0055, 1'b0);
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd[e.port*DW +: DW] !== e.data || rbusy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s port%0d: RD=%h RBUSY=%b, expected RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port], e.data, e.busy);
      end else $display("ok   %s port%0d RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port]);
    end
  endtask

  task automatic test_release_reserve();
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    tick();
    checks++;
    if (busy_vec !== 32'h0000_0008) begin
      errors++;
      $display("FAIL rsv_x3_busy: BUSY_VEC=%h expected %h", busy_vec, 32'h0000_0008);
    end
    // Release and re-reserve x3 on the same edge: new owner keeps it busy.
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'h0000_33CC;
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    re = 4'b0100; ra = pack_ra(5'd0, 5'd0, 5'd3, 5'd0);
    push_exp("rel_rsv_read_x3", 2, 32'h0000_33CC, 1'b1);
    #1;
    checks++;
    if (rsv_ready !== 1'b1) begin
      errors++;
      $display("FAIL rel_rsv_ready: RSV_READY=%b expected 1", rsv_ready);
    end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd[e.port*DW +: DW] !== e.data || rbusy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s port%0d: RD=%h RBUSY=%b, expected RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port], e.data, e.busy);
      end else $display("ok   %s port%0d RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port]);
    end
    checks++;
    if (busy_vec !== 32'h0000_0008) begin
      errors++;
      $display("FAIL rel_rsv_busy: BUSY_VEC=%h expected %h", busy_vec, 32'h0000_0008);
    end
    re = 4'b1000; ra = pack_ra(5'd0, 5'd0, 5'd0, 5'd3);
    push_exp("stored_read_x3", 3, 32'h0000_33CC, 1'b1);
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd[e.port*DW +: DW] !== e.data || rbusy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s port%0d: RD=%h RBUSY=%b, expected RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port], e.data, e.busy);
      end else $display("ok   %s port%0d RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port]);
    end
    // Final writeback clears x3.
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'h0000_33CC;
    tick();
    checks++;
    if (busy_vec !== '0) begin
      errors++;
      $display("FAIL release_x3_busy: BUSY_VEC=%h expected 0", busy_vec);
    end
  endtask

  task automatic test_four_ports();
    logic [AW-1:0] waddr [4];
    logic [31:0]   wdata [4];
    waddr[0] = 5'd1;  wdata[0] = 32'h0000_0011;
    waddr[1] = 5'd2;  wdata[1] = 32'h0000_0022;
    waddr[2] = 5'd4;  wdata[2] = 32'h0000_0044;
    waddr[3] = 5'd31; wdata[3] = 32'h0000_3131;
    for (int i = 0; i < 4; i++) begin
      we3 = 1'b1; a3 = waddr[i]; wd3 = wdata[i];
      tick();
    end
    re = 4'b0100; ra = pack_ra(5'd0, 5'd0, 5'd4, 5'd0);
    push_exp("preload_port2", 2, 32'h0000_0044, 1'b0);
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd[e.port*DW +: DW] !== e.data || rbusy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s port%0d: RD=%h RBUSY=%b, expected RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port], e.data, e.busy);
      end else $display("ok   %s port%0d RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port]);
    end
    re = 4'b1011; ra = pack_ra(5'd1, 5'd2, 5'd1, 5'd31);
    push_exp("quad_p0_x1", 0, 32'h0000_0011, 1'b0);
    push_exp("quad_p1_x2", 1, 32'h0000_0022, 1'b0);
    push_exp("quad_p2_hold", 2, 32'h0000_0044, 1'b0);
    push_exp("quad_p3_x31", 3, 32'h0000_3131, 1'b0);
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd[e.port*DW +: DW] !== e.data || rbusy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s port%0d: RD=%h RBUSY=%b, expected RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port], e.data, e.busy);
      end else $display("ok   %s port%0d RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [8];
    for (int i = 0; i < 8; i++) begin
      vals[i] = $urandom;
    end
    // Each cycle writes a new register, bypass-reads it on port 1 and reads
    // the previous cycle's register from storage on port 0.
    for (int i = 0; i < 8; i++) begin
      we3 = 1'b1; a3 = AW'(16 + i); wd3 = vals[i];
      if (i > 0) begin
        re = 4'b0011;
        ra = pack_ra(AW'(16 + i - 1), AW'(16 + i), 5'd0, 5'd0);
        push_exp("b2b_prev", 0, vals[i-1], 1'b0);
      end else begin
        re = 4'b0010;
        ra = pack_ra(5'd0, AW'(16 + i), 5'd0, 5'd0);
      end
      push_exp("b2b_bypass", 1, vals[i], 1'b0);
      tick();
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rd[e.port*DW +: DW] !== e.data || rbusy[e.port] !== e.busy) begin
          errors++;
          $display("FAIL %s port%0d: RD=%h RBUSY=%b, expected RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port], e.data, e.busy);
        end else $display("ok   %s port%0d RD=%h RBUSY=%b", e.name, e.port, rd[e.port*DW +: DW], rbusy[e.port]);
      end
    end
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_release_reserve();
    test_four_ports();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
